// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port registered data memory between the
// pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
//
// CPU normally wins. EXT gets the cycle when the CPU is idle, or when EXT
// has already waited STARVE_LIMIT consecutive cycles behind the CPU. In that
// case the CPU is stalled for that one cycle. Each issued read is tagged so
// that the memory data returned one cycle later goes to the right requester.
//
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   cpu_req/we/size/addr/wdata   CPU access request (size 00 B, 01 H, 10 W)
//   cpu_stall                    CPU access not accepted this cycle
//   cpu_rvalid/cpu_rdata         CPU load response, one cycle after grant
//   ext_valid/we/addr/wdata      EXT word request, held until ext_ready
//   ext_ready                    EXT request accepted this cycle
//   ext_rvalid/ext_rdata         EXT load response, one cycle after grant
//   mem_addr/wdata/we/re/size    memory request, driven by the winner
//   mem_rdata                    memory read data, one cycle after mem_re
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_cpu;
  logic       rd_ext;
  logic       grant_ext;
  logic       grant_cpu;

  // Grants are masked while reset is held so no access reaches memory and
  // no read gets tagged during the reset cycle.
  always_comb begin
    grant_ext = reset & ext_valid & (~cpu_req | (starve_cnt >= LIMIT));
    grant_cpu = reset & cpu_req & ~grant_ext;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_size  = 2'b00;
    if (grant_ext) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
      mem_re    = ~ext_we;
      mem_size  = 2'b10;
    end else if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      mem_size  = cpu_size;
    end
  end

  // cpu_stall is masked during reset; the pipeline is not running anyway.
  // Responses are masked too so a read in flight when reset arrives is
  // dropped rather than delivered.
  always_comb begin
    ext_ready  = grant_ext;
    cpu_stall  = reset & cpu_req & ~grant_cpu;
    cpu_rvalid = reset & rd_cpu;
    ext_rvalid = reset & rd_ext;
    cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    ext_rdata  = ext_rvalid ? mem_rdata : 32'h0;
  end

  // Request stage -> response stage: read tags and the starvation counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      rd_cpu     <= 1'b0;
      rd_ext     <= 1'b0;
    end else begin
      rd_cpu <= grant_cpu & ~cpu_we;
      rd_ext <= grant_ext & ~ext_we;
      if (grant_ext || !ext_valid)
        starve_cnt <= 4'd0;
      else if (cpu_req && starve_cnt != 4'd15)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port registered data memory between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- Arbitrates every cycle, with CPU priority and a starvation limit for EXT.
- When EXT wins a cycle in which the CPU also requests, it stalls the pipeline.
- Tags each issued read so the one-cycle-later memory data is routed back to the correct requester.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles EXT may wait while the CPU holds the memory before EXT is forced a grant; legal range 1-15.
- ADDR_W, 32: address width on all ports.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU memory access request this cycle (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word; passed through to memory
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU access not accepted this cycle; pipeline holds
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  32  CPU load data
- ext_valid  in  1  EXT request valid; held until accepted
- ext_ready  out  1  EXT request accepted this cycle
- ext_we  in  1  EXT store/load
- ext_addr  in  ADDR_W  EXT byte address; word accesses only
- ext_wdata  in  32  EXT store data
- ext_rvalid  out  1  EXT load data valid
- ext_rdata  out  32  EXT load data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_size  out  2  access size encoding, same as cpu_size
- mem_rdata  in  32  memory read data, valid one cycle after mem_re

Behaviour:
- Grant is combinational from inputs and starve_cnt (4-bit register).
- grant_ext = ext_valid & (!cpu_req | starve_cnt >= STARVE_LIMIT).
- grant_cpu = cpu_req & !grant_ext.
- Memory mux:
  - grant_cpu: mem_* driven from cpu_*.
  - grant_ext: mem_* driven from ext_*, mem_size = 10.
  - No grant: mem_we = 0, mem_re = 0, mem_addr/mem_wdata = 0.
- Handshakes:
  - mem_re = granted & !we.
  - ext_ready = grant_ext.
  - cpu_stall = cpu_req & !grant_cpu.
- Starvation counter:
  - Cleared when grant_ext = 1 or ext_valid = 0.
  - Increments when ext_valid & cpu_req & !grant_ext.
  - Saturates at 15.
- Read tagging:
  - Registered rd_cpu <= grant_cpu & !cpu_we; rd_ext <= grant_ext & !ext_we.
  - Next cycle: cpu_rvalid = rd_cpu, ext_rvalid = rd_ext.
  - cpu_rdata = rd_cpu ? mem_rdata : 0; ext_rdata = rd_ext ? mem_rdata : 0.
  - Load latency is exactly 1 cycle after grant.
- Back-to-back grants are legal every cycle, including read-after-write to the same address (memory ordering is the memory's responsibility).
- At most one access per cycle; rd_cpu and rd_ext are never both 1.
- Simultaneous requests below the limit: CPU wins, EXT waits.
- Simultaneous requests at the limit: EXT wins, cpu_stall = 1 for exactly that cycle, counter clears.
- Reset (reset = 0 at a clock edge): starve_cnt = 0, rd_cpu = 0, rd_ext = 0.
  - During the reset cycle, ext_ready, mem_we, mem_re and cpu_stall are forced 0 regardless of inputs.
  - Reset asserted mid-read discards the pending response: no rvalid the following cycle.
- Writes produce no rvalid on either port.

Test Plan:
- Reset low with cpu_req = 1, ext_valid = 1 -> mem_we = mem_re = 0, ext_ready = 0, cpu_stall = 0; next cycle after release, no rvalid.
- CPU load only: cpu_addr = 0x10, cpu_size = 10; memory returns 0xDEADBEEF -> mem_re = 1 in cycle N; cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF in N+1; ext_rvalid = 0.
- EXT store only: ext_addr = 0x20, ext_wdata = 0x12345678 -> ext_ready = 1, mem_we = 1, mem_size = 10 in the same cycle; no rvalid the next cycle.
- Continuous cpu_req with ext_valid held, STARVE_LIMIT = 4 -> CPU granted cycles 0-3; cycle 4 ext_ready = 1 and cpu_stall = 1; cycle 5 CPU granted again with starve_cnt = 0.
- Alternating EXT load (cycle N) then CPU load (cycle N+1) -> ext_rvalid in N+1 only, cpu_rvalid in N+2 only, each carrying its own mem_rdata.
- CPU load granted, reset asserted the next cycle -> cpu_rvalid stays 0; state is clean after release.
